serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder built around the team's full-adder cell: a single full-adder slice plus a carry flip-flop, processing operand pairs LSB-first, one bit per clock.
- Sits directly downstream of the full-adder stage. It consumes the cell's sum/carry outputs every cycle and assembles them into a WIDTH-bit result.
- Uses a start/busy/done handshake so a controller can issue one addition at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse when sum/cout are valid.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry FF and bit counter all cleared.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: on an edge with start=1, load a_sr←a, b_sr←b, carry←cin, cnt←0, then go to SHIFT. With start=0, stay in IDLE.
- SHIFT (busy=1): on each edge:
  - Full-adder inputs are (a_sr[0], b_sr[0], carry).
  - Shift the FA sum bit into the MSB of s_sr, with s_sr shifting right.
  - a_sr and b_sr shift right.
  - carry←FA carry-out; cnt←cnt+1.
  - On the edge where cnt==WIDTH-1: load sum←final s_sr (including the current bit), load cout←FA carry-out, then go to DONE.
- DONE (done=1, busy=0): for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge k → busy high for cycles after edges k..k+WIDTH-1 → done high in the cycle after edge k+WIDTH → IDLE again after edge k+WIDTH+1. Total is WIDTH+2 cycles from request to ready.
- start is ignored in SHIFT and DONE; it is not queued. Operand changes during SHIFT have no effect.
- Back-to-back operation: start may be held high. It is re-accepted on the first edge in IDLE.
- sum/cout never show partial results. They change only on the edge that enters DONE.
- Width rule: the result is modulo 2^WIDTH, with the overflowed bit in cout. Operands are treated as unsigned.
- rst_n asserted mid-SHIFT aborts the operation: all outputs go to 0 immediately and no done pulse is produced.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), with reset value 0.
  - ovf is loaded on the same edge as sum/cout, with the value (carry into MSB) XOR (carry out of MSB), i.e. two's-complement signed overflow.
  - The carry into the MSB is the carry FF value during the final SHIFT cycle.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → busy=0, done=0, sum=8'h00, cout=0 throughout.
- a=8'h00, b=8'h00, cin=0, pulse start → busy high for 8 cycles, done pulses exactly once 9 cycles after the start edge, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1 (full carry ripple); with OVF_EN, ovf=0.
- a=8'h5A, b=8'h33, cin=1 → sum=8'h8E, cout=0; with OVF_EN, ovf=1.
- Start a=8'h0F, b=8'h01, cin=0, then 3 cycles later drive start=1 with a=8'hAA, b=8'h55 → the second request is ignored, the first result is sum=8'h10, cout=0, and only one done pulse occurs.
- Start a=8'hF0, b=8'h0F; drop rst_n at SHIFT cycle 4 for 1 cycle → outputs 0 immediately, no done pulse. A fresh start with a=8'h80, b=8'h80, cin=0 then completes with sum=8'h00, cout=1 (ovf=1 with OVF_EN).

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice plus a carry flop, start/busy/done handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [1:0]       fa;
  logic [WIDTH-1:0] s_full;

  // Returns {carry_out, sum} of a single full-adder slice.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  // s_sr holds the bits collected so far, top-aligned; s_full appends the bit being produced now.
  always_comb begin
    fa     = full_add(a_sr_q[0], b_sr_q[0], carry_q);
    s_full = {fa[0], s_sr_q};
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_full[WIDTH-1:1];
        carry_d = fa[1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = s_full;
          cout_d  = fa[1];
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa[1];
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases from the test plan plus random operands
// compared against an arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference: plain unsigned addition, carry is the bit above the result.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Signed overflow: operands share a sign and the result sign differs.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one addition and observe it for W+4 cycles after the accepting edge.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         output int busy_cnt, output int done_cyc, output int done_cnt,
                         output logic [W-1:0] rsum, output logic rcout, output logic rovf,
                         output bit partial);
    logic [W-1:0] sum0;
    logic         cout0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_; bus.cin = tc;
    sum0 = bus.sum; cout0 = bus.cout;
    busy_cnt = 0; done_cyc = -1; done_cnt = 0; partial = 1'b0;
    rsum = '0; rcout = 1'b0; rovf = 1'b0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = i; rsum = bus.sum; rcout = bus.cout; rovf = get_ovf();
        end
      end else if (done_cyc < 0 && (bus.sum !== sum0 || bus.cout !== cout0)) begin
        partial = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.cout, bus.sum, get_ovf()} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: busy=%b done=%b cout=%b sum=%h, required all 0",
                 i, bus.busy, bus.done, bus.cout, bus.sum);
      end
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int bc, dc, dn; logic [W-1:0] s; logic co, ov; bit p;
    run_add(8'h00, 8'h00, 1'b0, bc, dc, dn, s, co, ov, p);
    checks++; if (bc !== W) begin errors++; $display("FAIL zero_busy_cycles got %0d required %0d", bc, W); end
    checks++; if (dc !== W + 1) begin errors++; $display("FAIL zero_done_latency got %0d required %0d", dc, W + 1); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL zero_done_pulses got %0d required 1", dn); end
    checks++; if ({co, s} !== 9'h000) begin errors++; $display("FAIL zero_result got %b_%h required 0_00", co, s); end
  endtask

  task automatic test_directed();
    int bc, dc, dn; logic [W-1:0] s; logic co, ov; bit p;
    run_add(8'hFF, 8'h01, 1'b0, bc, dc, dn, s, co, ov, p);
    checks++; if ({co, s} !== 9'h100) begin errors++; $display("FAIL ripple_result got %b_%h required 1_00", co, s); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL ripple_partial sum changed before done"); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ripple_ovf got %b required 0", ov); end
`endif
    run_add(8'h5A, 8'h33, 1'b1, bc, dc, dn, s, co, ov, p);
    checks++; if ({co, s} !== 9'h08E) begin errors++; $display("FAIL cin_result got %b_%h required 0_8e", co, s); end
    checks++; if (dc !== W + 1) begin errors++; $display("FAIL cin_done_latency got %0d required %0d", dc, W + 1); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL cin_ovf got %b required 1", ov); end
`endif
  endtask

  task automatic test_ignore_start();
    int dn; logic [W-1:0] s; logic co;
    dn = 0; s = '0; co = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0;
    for (int i = 1; i <= 2 * W + 6; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 3) begin bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) begin
        dn++;
        if (dn == 1) begin s = bus.sum; co = bus.cout; end
      end
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_pulses got %0d required 1", dn); end
    checks++; if ({co, s} !== 9'h010) begin errors++; $display("FAIL ignore_result got %b_%h required 0_10", co, s); end
  endtask

  task automatic test_abort();
    int dn, bc, dc; logic [W-1:0] s; logic co, ov; bit p;
    dn = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h0F; bus.cin = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.sum, get_ovf()} !== '0) begin
      errors++;
      $display("FAIL abort_outputs busy=%b done=%b cout=%b sum=%h, required all 0",
               bus.busy, bus.done, bus.cout, bus.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses required 0", dn); end
    run_add(8'h80, 8'h80, 1'b0, bc, dc, dn, s, co, ov, p);
    checks++; if ({co, s} !== 9'h100) begin errors++; $display("FAIL after_abort_result got %b_%h required 1_00", co, s); end
    checks++; if (dc !== W + 1) begin errors++; $display("FAIL after_abort_latency got %0d required %0d", dc, W + 1); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL after_abort_ovf got %b required 1", ov); end
`endif
  endtask

  task automatic test_random();
    int bc, dc, dn; logic [W-1:0] s, ra, rb; logic co, ov, rc; bit p;
    logic [W:0] exp;
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_add(ra, rb, rc, bc, dc, dn, s, co, ov, p);
      exp = ref_add(ra, rb, rc);
      checks++;
      if ({co, s} !== exp || dn !== 1 || p !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d %h+%h+%b: got %b_%h done=%0d partial=%b required %b_%h done=1 partial=0",
                 n, ra, rb, rc, co, s, dn, p, exp[W], exp[W-1:0]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ov !== ref_ovf(ra, rb, rc)) begin
        errors++;
        $display("FAIL rand%0d_ovf %h+%h+%b: got %b required %b", n, ra, rb, rc, ov, ref_ovf(ra, rb, rc));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, s1, s2; logic c1, c2, co1, co2;
    int d1, d2;
    logic [W:0] e1, e2;
    a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
    a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom);
    d1 = -1; d2 = -1; s1 = '0; s2 = '0; co1 = 1'b0; co2 = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a1; bus.b = b1; bus.cin = c1;
    for (int i = 1; i <= 3 * W; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = i; s1 = bus.sum; co1 = bus.cout;
          bus.a = a2; bus.b = b2; bus.cin = c2;
        end else if (d2 < 0) begin
          d2 = i; s2 = bus.sum; co2 = bus.cout;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    e1 = ref_add(a1, b1, c1);
    e2 = ref_add(a2, b2, c2);
    checks++; if (d1 !== W + 1) begin errors++; $display("FAIL b2b_first_done got %0d required %0d", d1, W + 1); end
    checks++; if (d2 !== 2 * W + 3) begin errors++; $display("FAIL b2b_second_done got %0d required %0d", d2, 2 * W + 3); end
    checks++; if ({co1, s1} !== e1) begin errors++; $display("FAIL b2b_first_result got %b_%h required %b_%h", co1, s1, e1[W], e1[W-1:0]); end
    checks++; if ({co2, s2} !== e2) begin errors++; $display("FAIL b2b_second_result got %b_%h required %b_%h", co2, s2, e2[W], e2[W-1:0]); end
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    test_reset();
    test_zero();
    test_directed();
    test_ignore_start();
    test_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
